// File: rtl/oam_dma_engine.sv
// OAM DMA initiator: on an FF46 write it copies NUM_BYTES from {src,00} into OAM.
// Optional abort input is enabled with the OAM_DMA_ABORT_EN macro.
module oam_dma_engine #(
    parameter int START_DELAY     = 4,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int READ_LATENCY    = 1,
    parameter int NUM_BYTES       = 160
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iRegWe,
    input  logic [7:0]  iRegData,
`ifdef OAM_DMA_ABORT_EN
    input  logic        iAbort,
`endif
    output logic [7:0]  oDmaReg,
    output logic        oDmaActive,
    output logic        oReadReq,
    output logic [15:0] oReadAddr,
    input  logic [7:0]  iReadData,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData
);

    localparam int SW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(CYCLES_PER_BYTE - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(START_DELAY - 1);
    localparam logic [7:0]    I_LAST = 8'(NUM_BYTES - 1);

    if (START_DELAY < 1) begin : g_bad_delay
        $error("START_DELAY must be at least 1");
    end
    if (CYCLES_PER_BYTE < READ_LATENCY + 1) begin : g_bad_slot
        $error("CYCLES_PER_BYTE must exceed READ_LATENCY");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 256) begin : g_bad_len
        $error("NUM_BYTES must be 1..256");
    end

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t        state_q, state_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    src_q, src_d;
    logic [7:0]    idx_q, idx_d;
    logic [SW-1:0] s_q, s_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          abort_q, abort_d;
    logic          abort;
    logic [7:0]    src_map;
    logic          xfer;
    logic          slot_end;

`ifdef OAM_DMA_ABORT_EN
    assign abort = iAbort;
`else
    assign abort = 1'b0;
`endif

    // E0-FF mirrors work RAM at C0-DF
    assign src_map  = (iRegData >= 8'hE0) ? iRegData - 8'h20 : iRegData;
    assign xfer     = (state_q == XFER);
    assign slot_end = (s_q == S_LAST);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            reg_q   <= 8'hFF;
            src_q   <= 8'h00;
            idx_q   <= 8'h00;
            s_q     <= '0;
            dly_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            dly_q   <= dly_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        src_d   = src_q;
        idx_d   = idx_q;
        s_d     = s_q;
        dly_d   = dly_q;
        abort_d = abort_q;
        if (iRegWe) begin
            // a new FF46 write always (re)starts, beating abort and completion
            state_d = START;
            reg_d   = iRegData;
            src_d   = src_map;
            idx_d   = 8'h00;
            s_d     = '0;
            dly_d   = D_LOAD;
            abort_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                START: begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (dly_q == '0) begin
                        state_d = XFER;
                        idx_d   = 8'h00;
                        s_d     = '0;
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end
                XFER: begin
                    if (slot_end) begin
                        s_d     = '0;
                        abort_d = 1'b0;
                        if (idx_q == I_LAST || abort_q || abort) begin
                            state_d = IDLE;
                            idx_d   = 8'h00;
                        end else begin
                            idx_d = idx_q + 8'h01;
                        end
                    end else begin
                        s_d     = s_q + 1'b1;
                        abort_d = abort_q | abort;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign oDmaReg    = reg_q;
    assign oDmaActive = (state_q != IDLE);
    assign oReadReq   = xfer && (s_q == '0);
    assign oReadAddr  = xfer ? {src_q, idx_q} : 16'h0000;
    assign oOamWe     = xfer && slot_end;
    assign oOamAddr   = oOamWe ? idx_q : 8'h00;
    assign oOamData   = oOamWe ? iReadData : 8'h00;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: default instance plus a
// READ_LATENCY=2 / CYCLES_PER_BYTE=3 instance for pacing.
module tb_oam_dma_engine;

    logic        iClock, iReset;
    logic        iRegWe, iRegWe2;
    logic [7:0]  iRegData, iRegData2;
    logic        iAbort, iAbort2;
    logic [7:0]  oDmaReg, oDmaReg2;
    logic        oDmaActive, oDmaActive2;
    logic        oReadReq, oReadReq2;
    logic [15:0] oReadAddr, oReadAddr2;
    logic [7:0]  iReadData, iReadData2;
    logic        oOamWe, oOamWe2;
    logic [7:0]  oOamAddr, oOamAddr2;
    logic [7:0]  oOamData, oOamData2;

    oam_dma_engine u_dut (
        .iClock(iClock), .iReset(iReset),
        .iRegWe(iRegWe), .iRegData(iRegData),
`ifdef OAM_DMA_ABORT_EN
        .iAbort(iAbort),
`endif
        .oDmaReg(oDmaReg), .oDmaActive(oDmaActive),
        .oReadReq(oReadReq), .oReadAddr(oReadAddr),
        .iReadData(iReadData), .oOamWe(oOamWe),
        .oOamAddr(oOamAddr), .oOamData(oOamData)
    );

    oam_dma_engine #(
        .START_DELAY(4), .CYCLES_PER_BYTE(3),
        .READ_LATENCY(2), .NUM_BYTES(160)
    ) u_pace (
        .iClock(iClock), .iReset(iReset),
        .iRegWe(iRegWe2), .iRegData(iRegData2),
`ifdef OAM_DMA_ABORT_EN
        .iAbort(iAbort2),
`endif
        .oDmaReg(oDmaReg2), .oDmaActive(oDmaActive2),
        .oReadReq(oReadReq2), .oReadAddr(oReadAddr2),
        .iReadData(iReadData2), .oOamWe(oOamWe2),
        .oOamAddr(oOamAddr2), .oOamData(oOamData2)
    );

    function automatic logic [7:0] mem(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0] * 8'd7;
        return lo ^ a[15:8] ^ 8'h3C;
    endfunction

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    logic [7:0] rd1, rd2a, rd2b;
    always @(posedge iClock) begin
        rd1  <= mem(oReadAddr);
        rd2a <= mem(oReadAddr2);
        rd2b <= rd2a;
    end
    assign iReadData  = rd1;
    assign iReadData2 = rd2b;

    logic [7:0]  oam [0:255];
    logic [7:0]  waddr_q [$];
    logic [15:0] raddr_q [$];
    int wcount, act_cnt, rises, fall_cyc, last_we_cyc;
    logic prev_act = 1'b0;
    int act2_cnt, we2_cnt, rr2_cyc, pace_err, data_err2;

    always @(negedge iClock) begin
        if (oDmaActive && !prev_act) rises++;
        if (!oDmaActive && prev_act) fall_cyc = cyc;
        prev_act = oDmaActive;
        if (oDmaActive) act_cnt++;
        if (oReadReq) raddr_q.push_back(oReadAddr);
        if (oOamWe) begin
            oam[oOamAddr] = oOamData;
            waddr_q.push_back(oOamAddr);
            wcount++;
            last_we_cyc = cyc;
        end
        if (oDmaActive2) act2_cnt++;
        if (oReadReq2) rr2_cyc = cyc;
        if (oOamWe2) begin
            we2_cnt++;
            if (cyc - rr2_cyc != 2) pace_err++;
            if (oOamData2 !== mem({8'h45, oOamAddr2})) data_err2++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        waddr_q.delete();
        raddr_q.delete();
        wcount = 0; act_cnt = 0; rises = 0;
        fall_cyc = 0; last_we_cyc = 0;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge iClock);
        iRegWe = 1'b1; iRegData = d;
        @(negedge iClock);
        iRegWe = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (oDmaActive && n < 3000) begin
            @(negedge iClock); #1;
            n++;
        end
        chk(tag, 32'(oDmaActive), 32'd0);
    endtask

    task automatic wait_slot(input logic [7:0] s, input string tag);
        int n = 0;
        do begin
            @(negedge iClock); #1;
            n++;
        end while (!(oReadReq && oReadAddr[7:0] == s) && n < 3000);
        chk(tag, 32'(oReadReq), 32'd1);
    endtask

    int e;

    initial begin
        iReset = 1'b1; iRegWe = 1'b0; iRegData = 8'h00;
        iRegWe2 = 1'b0; iRegData2 = 8'h00;
        iAbort = 1'b0; iAbort2 = 1'b0;
        clr();
        act2_cnt = 0; we2_cnt = 0; rr2_cyc = 0;
        pace_err = 0; data_err2 = 0;
        repeat (3) @(negedge iClock);
        #1;
        chk("rst_reg", 32'(oDmaReg), 32'hFF);
        chk("rst_active", 32'(oDmaActive), 32'd0);
        chk("rst_rreq", 32'(oReadReq), 32'd0);
        chk("rst_raddr", 32'(oReadAddr), 32'd0);
        chk("rst_we", 32'(oOamWe), 32'd0);
        chk("rst_oaddr", 32'(oOamAddr), 32'd0);
        chk("rst_odata", 32'(oOamData), 32'd0);
        @(negedge iClock);
        iReset = 1'b0;
        repeat (2) @(negedge iClock);

        // plain transfer from C100
        clr();
        wr(8'hC1);
        wait_idle("t1_timeout");
        chk("t1_active_clks", 32'(act_cnt), 32'd644);
        chk("t1_we_count", 32'(wcount), 32'd160);
        chk("t1_rises", 32'(rises), 32'd1);
        chk("t1_reg", 32'(oDmaReg), 32'hC1);
        e = 0;
        for (int i = 0; i < 160; i++) begin
            if (i >= waddr_q.size() || waddr_q[i] !== 8'(i)) e++;
            if (i >= raddr_q.size() || raddr_q[i] !== 16'hC100 + 16'(i)) e++;
            if (oam[i] !== mem(16'hC100 + 16'(i))) e++;
        end
        chk("t1_addr_data_errs", 32'(e), 32'd0);

        // echo-mirror source
        clr();
        wr(8'hF3);
        wait_idle("t2_timeout");
        chk("t2_reg", 32'(oDmaReg), 32'hF3);
        chk("t2_rreq_count", 32'(raddr_q.size()), 32'd160);
        e = 0;
        for (int i = 0; i < 160; i++)
            if (i >= raddr_q.size() || raddr_q[i] !== 16'hD300 + 16'(i)) e++;
        chk("t2_raddr_errs", 32'(e), 32'd0);

        // restart after 50 writes
        clr();
        wr(8'h80);
        e = 0;
        while (wcount < 50 && e < 2000) begin
            @(negedge iClock); #1;
            e++;
        end
        chk("t3_reach50", 32'(wcount), 32'd50);
        wr(8'h90);
        repeat (3) @(negedge iClock);
        #1;
        chk("t3_still_start", 32'(oReadReq), 32'd0);
        chk("t3_active_hold", 32'(oDmaActive), 32'd1);
        @(negedge iClock);
        #1;
        chk("t3_first_rreq", 32'(oReadReq), 32'd1);
        chk("t3_first_raddr", 32'(oReadAddr), 32'h9000);
        wait_idle("t3_timeout");
        chk("t3_we_total", 32'(wcount), 32'd210);
        chk("t3_rises", 32'(rises), 32'd1);
        chk("t3_reg", 32'(oDmaReg), 32'h90);
        e = 0;
        for (int i = 0; i < 160; i++)
            if (oam[i] !== mem(16'h9000 + 16'(i))) e++;
        chk("t3_oam_errs", 32'(e), 32'd0);

        // asynchronous reset at slot 20
        clr();
        wr(8'hC1);
        wait_slot(8'd20, "t4_reach_slot20");
        #2 iReset = 1'b1;
        #1;
        chk("t4_reg", 32'(oDmaReg), 32'hFF);
        chk("t4_active", 32'(oDmaActive), 32'd0);
        chk("t4_rreq", 32'(oReadReq), 32'd0);
        chk("t4_raddr", 32'(oReadAddr), 32'd0);
        chk("t4_we", 32'(oOamWe), 32'd0);
        chk("t4_oaddr", 32'(oOamAddr), 32'd0);
        chk("t4_odata", 32'(oOamData), 32'd0);
        @(negedge iClock);
        iReset = 1'b0;
        repeat (700) @(negedge iClock);
        #1;
        chk("t4_we_count", 32'(wcount), 32'd20);
        chk("t4_idle", 32'(oDmaActive), 32'd0);

        // pacing with READ_LATENCY=2, CYCLES_PER_BYTE=3
        @(negedge iClock);
        iRegWe2 = 1'b1; iRegData2 = 8'h45;
        @(negedge iClock);
        iRegWe2 = 1'b0;
        e = 0;
        while (oDmaActive2 && e < 3000) begin
            @(negedge iClock); #1;
            e++;
        end
        chk("t5_timeout", 32'(oDmaActive2), 32'd0);
        chk("t5_we_count", 32'(we2_cnt), 32'd160);
        chk("t5_pace_errs", 32'(pace_err), 32'd0);
        chk("t5_data_errs", 32'(data_err2), 32'd0);
        chk("t5_active_clks", 32'(act2_cnt), 32'd484);
        chk("t5_reg", 32'(oDmaReg2), 32'h45);

`ifdef OAM_DMA_ABORT_EN
        // abort during slot 10
        clr();
        wr(8'hC1);
        wait_slot(8'd10, "t6_reach_slot10");
        iAbort = 1'b1;
        @(negedge iClock);
        iAbort = 1'b0;
        wait_idle("t6_timeout");
        chk("t6_we_count", 32'(wcount), 32'd11);
        chk("t6_last_waddr", 32'(waddr_q[waddr_q.size()-1]), 32'd10);
        chk("t6_fall_delay", 32'(fall_cyc - last_we_cyc), 32'd1);
        chk("t6_reg", 32'(oDmaReg), 32'hC1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
